// File: rtl/display_counter.sv
// display_counter
//   Two-digit count generator feeding a pair of 7-segment decoders. Two raw
//   push-buttons are debounced; a Mode press cycles the display mode
//   (hex -> decimal -> even -> spinner -> hex) and clears the digits, an Inc
//   press applies one step of the active mode's count rule.
//
//   Optional feature macro: DISPLAY_COUNTER_AUTORUN_EN
//     When defined, a prescaler emits a step tick every TICK_DIV cycles.
//
// Parameters
//   DEBOUNCE_LIMIT  cycles a raw input must differ before the debounced state flips (>= 2)
//   TICK_DIV        auto-run step period in cycles (>= 2, auto-run build only)
// Ports
//   i_Clk          clock, all logic on the rising edge
//   i_Rst          synchronous active-high reset
//   i_Switch_Inc   raw increment button, high = pressed
//   i_Switch_Mode  raw mode button, high = pressed
//   o_Mode         display mode: 00 hex, 01 decimal, 10 even, 11 spinner
//   o_Digit_Hi     upper digit value
//   o_Digit_Lo     lower digit value
//   o_Update       one-cycle pulse in the cycle the outputs take a new value
//
// There is no valid/ready handshake: button events are fire-and-forget and
// o_Update is a pure strobe with no back-pressure.
module display_counter #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int TICK_DIV       = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_Inc,
  input  logic       i_Switch_Mode,
  output logic [1:0] o_Mode,
  output logic [3:0] o_Digit_Hi,
  output logic [3:0] o_Digit_Lo,
  output logic       o_Update
);

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_debounce_limit
    $error("DEBOUNCE_LIMIT must be at least 2");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    MODE_HEX  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_EVEN = 2'b10,
    MODE_SPIN = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------
  // Debouncers: index 0 = Inc, index 1 = Mode
  // ---------------------------------------------------------------------
  localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

  logic [1:0]      raw;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      db_q, db_d;
  logic [1:0]      prev_q;
  logic [1:0]      press;
  logic            inc_press, mode_press;

  assign raw = {i_Switch_Mode, i_Switch_Inc};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (raw[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      db_q        <= '0;
      prev_q      <= '0;
    end else begin
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      db_q        <= db_d;
      prev_q      <= db_q;
    end
  end

  // Press = rising edge of the debounced level; releases are ignored.
  assign press      = db_q & ~prev_q;
  assign inc_press  = press[0];
  assign mode_press = press[1];

  // ---------------------------------------------------------------------
  // Auto-run prescaler
  // ---------------------------------------------------------------------
  logic tick;

`ifdef DISPLAY_COUNTER_AUTORUN_EN
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  assign tick = (ps_q == PS_LAST);

  // A mode change restarts the period so the first step in the new mode
  // comes a full TICK_DIV cycles later.
  always_comb begin
    ps_d = ps_q + 1'b1;
    if (mode_press || tick) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign tick = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Mode FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------
  mode_e       state_q, state_d;
  logic [3:0]  dig_max;
  logic [3:0]  dig_step;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= MODE_HEX;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        MODE_HEX:  state_d = MODE_DEC;
        MODE_DEC:  state_d = MODE_EVEN;
        MODE_EVEN: state_d = MODE_SPIN;
        default:   state_d = MODE_HEX;
      endcase
    end
  end

  // The FSM state is the visible mode; it also selects each digit's last
  // value and step size.
  always_comb begin
    o_Mode   = state_q;
    dig_max  = 4'd15;
    dig_step = 4'd1;
    case (state_q)
      MODE_HEX:  begin dig_max = 4'd15; dig_step = 4'd1; end
      MODE_DEC:  begin dig_max = 4'd9;  dig_step = 4'd1; end
      MODE_EVEN: begin dig_max = 4'd8;  dig_step = 4'd2; end
      default:   begin dig_max = 4'd11; dig_step = 4'd1; end
    endcase
  end

  // ---------------------------------------------------------------------
  // Digit datapath
  // ---------------------------------------------------------------------
  logic       step_req;
  logic [3:0] hi_q, hi_d, lo_q, lo_d;
  logic       upd_q, upd_d;

  // An Inc press and a tick in the same cycle collapse into one step.
  assign step_req = inc_press | tick;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    upd_d = 1'b0;
    if (mode_press) begin
      // Mode change wins over a coincident step and clears both digits.
      hi_d  = '0;
      lo_d  = '0;
      upd_d = 1'b1;
    end else if (step_req) begin
      upd_d = 1'b1;
      if (lo_q == dig_max) begin
        lo_d = '0;
        hi_d = (hi_q == dig_max) ? 4'd0 : hi_q + dig_step;
      end else begin
        lo_d = lo_q + dig_step;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      upd_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      upd_q <= upd_d;
    end
  end

  assign o_Digit_Hi = hi_q;
  assign o_Digit_Lo = lo_q;
  assign o_Update   = upd_q;

endmodule

// File: doc/display_counter.md
# display_counter

Two-digit count generator that drives the pair of 7-segment decoders on the board. It debounces the two raw push-button inputs and keeps a mode register plus a two-nibble count. The count advances according to the active display mode: hex, decimal, even-only or spinner. Its outputs connect directly to each decoder's mode and 4-bit number inputs: o_Mode goes to both decoders, o_Digit_Hi to the tens decoder and o_Digit_Lo to the ones decoder.

## Interface
- DEBOUNCE_LIMIT, 250000: consecutive cycles a raw switch must differ from its debounced state before the debounced state flips (10 ms at 25 MHz); minimum 2.
- TICK_DIV, 25000000: auto-run step period in cycles; used only when auto-run is compiled in; minimum 2.
- i_Clk  in  1  system clock; one clock; everything is synchronous to its rising edge.
- i_Rst  in  1  reset; synchronous and active-high.
- i_Switch_Inc  in  1  raw increment button; high = pressed.
- i_Switch_Mode  in  1  raw mode button; high = pressed.
- o_Mode  out  2  display mode: 00 hex, 01 decimal, 10 even, 11 spinner.
- o_Digit_Hi  out  4  upper digit value.
- o_Digit_Lo  out  4  lower digit value.
- o_Update  out  1  one-cycle pulse, high in the cycle the outputs take a new value.

## Operation
- **Debouncers.** Two independent debouncers, one per switch.
  - Each has a counter and a debounced state.
  - Counter clears whenever the raw input equals the debounced state.
  - Otherwise the counter increments each cycle; on reaching DEBOUNCE_LIMIT-1 while still different, the debounced state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_LIMIT cycles produces no event.
- **Press event.** Rising edge of a debounced state (debounced high, previous-cycle debounced low). Releases generate nothing.
- **Mode state machine.** Four states, 00 → 01 → 10 → 11 → 00, advanced only by a Mode press. Every mode change clears both digits to 0.
- **Step rule per mode.** Applied once per Inc press (or auto tick).
  - 00 hex: Lo+1 mod 16; Lo wrapping 15→0 increments Hi mod 16. FF → 00.
  - 01 decimal (BCD): Lo+1 mod 10; Lo wrapping 9→0 increments Hi mod 10. 99 → 00.
  - 10 even: Lo+2 over {0,2,4,6,8}; Lo wrapping 8→0 steps Hi the same way. 88 → 00. Digits are always even.
  - 11 spinner: Lo+1 mod 12; Lo wrapping 11→0 increments Hi mod 12. Hi:Lo = 11:11 → 0:0.
- **Simultaneous events.**
  - Mode press and Inc press (or tick) in the same cycle: mode advance and clear win; the step is dropped.
  - Inc press and auto tick in the same cycle: exactly one step.
- Digits never hold a value outside the active mode's range. Mode changes clear the digits, so no range translation is required.

## Timing
- **Reset values:** o_Mode=00, o_Digit_Hi=0, o_Digit_Lo=0, o_Update=0. Debounced states, debounce counters, edge history and prescaler are all 0.
- **Reset mid-operation** returns everything to reset values in the next cycle.
  - A button held through reset debounces afresh and produces one press event DEBOUNCE_LIMIT cycles after reset deasserts.
- **Latency:** raw input first sampled high at edge N.
  - Debounced state high after edge N+DEBOUNCE_LIMIT-1.
  - Registered outputs update and o_Update is high after edge N+DEBOUNCE_LIMIT.
- All outputs are registered; no combinational path from inputs to outputs.
- o_Update asserts for exactly one cycle per accepted event, including a mode change and a wrap to 00. At most one event is accepted per cycle.

## Configuration
- **DISPLAY_COUNTER_AUTORUN_EN defined:**
  - A prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick on its terminal count; each tick applies one step.
  - The prescaler clears on reset and on every mode change.
- **Not defined:** no prescaler logic exists; only Inc presses step the count; TICK_DIV is unused.

## Test plan
- Reset, DEBOUNCE_LIMIT=4: Inc held high from edge N → o_Digit_Lo 0→1 with o_Update pulse after edge N+4; held longer → no further change.
- 3-cycle Inc glitch, DEBOUNCE_LIMIT=4 → no o_Update pulse; outputs unchanged.
- Mode 00: 255 Inc presses → Hi:Lo=F:F. One more → 0:0 with o_Update pulse.
- Mode press from 01 with count 4:7 → o_Mode=10, digits 0:0. Five Inc presses → 0:0, 0:2, 0:4, 0:6, 0:8, then 2:0.
- Mode and Inc debounced edges in the same cycle in mode 11 at 3:5 → o_Mode=00, digits 0:0, single o_Update pulse.
- Macro defined, TICK_DIV=10, no buttons → Lo increments every 10 cycles; decimal mode wraps 9:9 → 0:0. Mode press restarts the 10-cycle period.
